// File: rtl/ibex_instr_bus_buffer.sv
// Registered slice between the icache fetch port and instruction memory.
// Caps fetches in flight and flags memory responses that arrive with nothing outstanding.
module ibex_instr_bus_buffer #(
  parameter int BusSize        = 32,
  parameter int NumOutstanding = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               host_req_i,
  output logic               host_gnt_o,
  input  logic [31:0]        host_addr_i,
  output logic               host_rvalid_o,
  output logic [BusSize-1:0] host_rdata_o,
  output logic               host_err_o,
  output logic               mem_req_o,
  input  logic               mem_gnt_i,
  output logic [31:0]        mem_addr_o,
  input  logic               mem_rvalid_i,
  input  logic [BusSize-1:0] mem_rdata_i,
  input  logic               mem_err_i,
  output logic               busy_o,
  output logic               rsp_unexpected_o
);

  localparam int CntW = $clog2(NumOutstanding + 1);
  localparam logic [CntW:0]   MaxOcc = NumOutstanding[CntW:0];
  localparam logic [CntW-1:0] CntOne = 1;

  logic            req_valid_q;
  logic [31:0]     addr_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW:0]   occupancy;
  logic            accept;
  logic            mem_fire;
  logic            rsp_dec;

  assign occupancy = {1'b0, cnt_q} + {{CntW{1'b0}}, req_valid_q};
  // Gate on rst_i so the grant is low while reset is held, whatever the cache drives.
  assign accept    = host_req_i && !rst_i && (occupancy < MaxOcc) &&
                     (!req_valid_q || mem_gnt_i);
  assign mem_fire  = req_valid_q && mem_gnt_i;
  assign rsp_dec   = mem_rvalid_i && (cnt_q != '0);

  assign host_gnt_o = accept;
  assign mem_req_o  = req_valid_q;
  assign mem_addr_o = addr_q;
  assign busy_o     = req_valid_q || (cnt_q != '0) || host_rvalid_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        req_valid_q <= 1'b1;
        addr_q      <= host_addr_i;
      end else if (mem_gnt_i) begin
        req_valid_q <= 1'b0;
      end
      if (mem_fire && !rsp_dec) begin
        cnt_q <= cnt_q + CntOne;
      end else if (!mem_fire && rsp_dec) begin
        cnt_q <= cnt_q - CntOne;
      end
    end
  end

  // Responses are never stalled: the cache must take every rvalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      host_rvalid_o    <= 1'b0;
      host_rdata_o     <= '0;
      host_err_o       <= 1'b0;
      rsp_unexpected_o <= 1'b0;
    end else begin
      host_rvalid_o <= mem_rvalid_i;
      if (mem_rvalid_i) begin
        host_rdata_o <= mem_rdata_i;
        host_err_o   <= mem_err_i;
        if (cnt_q == '0) begin
          rsp_unexpected_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_instr_bus_buffer.sv
// Randomized and directed bench for ibex_instr_bus_buffer against a transaction-level model.
module tb_ibex_instr_bus_buffer;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_req = 1'b0;
  logic        host_gnt;
  logic [31:0] host_addr = '0;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        host_err;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err = 1'b0;
  logic        busy;
  logic        rsp_unexpected;

  ibex_instr_bus_buffer #(.BusSize(32), .NumOutstanding(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .busy_o(busy), .rsp_unexpected_o(rsp_unexpected)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: requests waiting for a memory grant, and fetches granted but not yet answered.
  logic [31:0] pend[$];
  int          out_cnt;
  logic        exp_rvalid, exp_err, exp_unexp;
  logic [31:0] exp_rdata, last_addr;

  logic        obs_gnt, obs_req, obs_rvalid, obs_err, obs_unexp, obs_busy;
  logic [31:0] obs_addr, obs_rdata;
  logic [31:0] dut_log[$];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    out_cnt   = 0;
    exp_rvalid = 1'b0;
    exp_err   = 1'b0;
    exp_unexp = 1'b0;
    exp_rdata = '0;
    last_addr = '0;
  endtask

  task automatic check_reset(input string pfx);
    chk_val({pfx, "_mem_req"}, mem_req, 0);
    chk_val({pfx, "_mem_addr"}, mem_addr, 0);
    chk_val({pfx, "_busy"}, busy, 0);
    chk_val({pfx, "_host_gnt"}, host_gnt, 0);
    chk_val({pfx, "_rvalid"}, host_rvalid, 0);
    chk_val({pfx, "_rdata"}, host_rdata, 0);
    chk_val({pfx, "_err"}, host_err, 0);
    chk_val({pfx, "_unexp"}, rsp_unexpected, 0);
  endtask

  task automatic cycle(input logic req, input logic [31:0] addr, input logic gnt,
                       input logic rv, input logic [31:0] data, input logic err);
    logic exp_gnt;
    int   old;
    @(negedge clk);
    host_req = req; host_addr = addr; mem_gnt = gnt;
    mem_rvalid = rv; mem_rdata = data; mem_err = err;
    #1;
    exp_gnt = req && (out_cnt + pend.size() < N) && (pend.size() == 0 || gnt);
    obs_gnt = host_gnt; obs_req = mem_req; obs_addr = mem_addr; obs_busy = busy;
    obs_rvalid = host_rvalid; obs_rdata = host_rdata; obs_err = host_err;
    obs_unexp = rsp_unexpected;
    if (mem_req && gnt) dut_log.push_back(mem_addr);
    chk_val("host_gnt", host_gnt, exp_gnt);
    chk_val("mem_req", mem_req, pend.size() != 0);
    chk_val("mem_addr", mem_addr, last_addr);
    chk_val("busy", busy, (pend.size() != 0) || (out_cnt != 0) || exp_rvalid);
    chk_val("host_rvalid", host_rvalid, exp_rvalid);
    chk_val("host_rdata", host_rdata, exp_rdata);
    chk_val("host_err", host_err, exp_err);
    chk_val("rsp_unexpected", rsp_unexpected, exp_unexp);
    @(posedge clk);
    old = out_cnt;
    if (pend.size() != 0 && gnt) begin
      void'(pend.pop_front());
      out_cnt++;
    end
    if (rv) begin
      if (old > 0) out_cnt--;
      else exp_unexp = 1'b1;
      exp_rdata = data;
      exp_err   = err;
    end
    exp_rvalid = rv;
    if (exp_gnt) begin
      pend.push_back(addr);
      last_addr = addr;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (out_cnt > 0 || pend.size() > 0); i++)
      cycle(1'b0, '0, 1'b1, out_cnt > 0, $urandom, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk_val("drain_busy", obs_busy, 0);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++)
      cycle(($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC, ($urandom % 3) != 0,
            (out_cnt > 0) && ($urandom % 2 == 1), $urandom, ($urandom % 8) == 0);
  endtask

  initial begin
    int          grants;
    logic [31:0] nxt;
    logic        sched[0:47];

    model_reset();
    host_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    host_req = 1'b0;
    rst = 1'b0;

    // Single fetch
    cycle(1'b1, 32'h0000_1000, 1'b1, 1'b0, '0, 1'b0);
    chk_val("single_gnt", obs_gnt, 1);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk_val("single_mem_req", obs_req, 1);
    chk_val("single_mem_addr", obs_addr, 32'h0000_1000);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk_val("single_rvalid", obs_rvalid, 1);
    chk_val("single_rdata", obs_rdata, 32'hDEAD_BEEF);
    chk_val("single_err", obs_err, 0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk_val("single_busy", obs_busy, 0);

    // Stream with responses two cycles after each memory grant
    nxt = 32'h100;
    dut_log.delete();
    for (int i = 0; i < 48; i++) sched[i] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, nxt, 1'b1, sched[i], $urandom, 1'b0);
      if (obs_gnt) nxt += 32'h4;
      if (obs_req) sched[i + 2] = 1'b1;
    end
    for (int i = 16; i < 18; i++) cycle(1'b0, '0, 1'b1, sched[i], $urandom, 1'b0);
    drain();
    chk_val("stream_count_ok", dut_log.size() >= 3, 1);
    for (int k = 0; k < 3; k++)
      if (k < dut_log.size()) chk_val("stream_addr", dut_log[k], 32'h100 + 32'(4 * k));

    // Credit limit
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0, '0, 1'b0);
      grants += int'(obs_gnt);
    end
    chk_val("credit_grants", grants, 2);
    chk_val("credit_gnt_low", obs_gnt, 0);
    chk_val("credit_req_low", obs_req, 0);
    cycle(1'b1, 32'h220, 1'b1, 1'b1, 32'h1111_2222, 1'b0);
    chk_val("credit_no_bypass", obs_gnt, 0);
    cycle(1'b1, 32'h220, 1'b1, 1'b0, '0, 1'b0);
    chk_val("credit_regrant", obs_gnt, 1);
    drain();

    // Grant stall
    cycle(1'b1, 32'h300, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h304, 1'b0, 1'b0, '0, 1'b0);
      chk_val("stall_gnt", obs_gnt, 0);
      chk_val("stall_req", obs_req, 1);
      chk_val("stall_addr", obs_addr, 32'h300);
    end
    cycle(1'b1, 32'h304, 1'b1, 1'b0, '0, 1'b0);
    chk_val("stall_release_gnt", obs_gnt, 1);
    drain();

    // Error response
    cycle(1'b1, 32'h400, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'hBAD0_0BAD, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk_val("err_rvalid", obs_rvalid, 1);
    chk_val("err_flag", obs_err, 1);
    drain();

    // Unexpected response with nothing outstanding
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk_val("unexp_before", obs_unexp, 0);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      chk_val("unexp_sticky", obs_unexp, 1);
    end
    chk_val("unexp_cnt_zero_busy", obs_busy, 0);

    random_run(400);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #3;
    host_req = 1'b1;
    rst = 1'b1;
    #1;
    check_reset("arst");
    @(posedge clk);
    @(negedge clk);
    host_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    rst = 1'b0;
    model_reset();

    random_run(150);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
